// File: rtl/vector_dispatch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vector_dispatch_ctrl_pkg
// Purpose  : Shared types and constants for the vector dispatch controller.
// Revision : 1.0
// ============================================================================
package vector_dispatch_ctrl_pkg;

  localparam int unsigned VDC_OP_W  = 4;
  localparam int unsigned VDC_REG_W = 5;
  localparam int unsigned VDC_DW    = 32;

  // Opcode encoding: bit 3 selects external write data, bit 2 the scalar operand.
  localparam logic [VDC_OP_W-1:0] VDC_OP_READ       = 4'b1000;
  localparam int unsigned         VDC_OP_EXT_BIT    = 3;
  localparam int unsigned         VDC_OP_SCALAR_BIT = 2;

  typedef enum logic [2:0] {
    s_IDLE  = 3'd0,
    s_ISSUE = 3'd1,
    s_WAIT  = 3'd2,
    s_DONE  = 3'd3,
    s_ERR   = 3'd4
  } vdc_state_e;

  typedef struct packed {
    logic [VDC_OP_W-1:0]  op;
    logic [VDC_REG_W-1:0] vd;
    logic [VDC_REG_W-1:0] vs1;
    logic [VDC_REG_W-1:0] vs2;
    logic [VDC_DW-1:0]    scalar;
    logic [VDC_DW-1:0]    data;
  } vdc_instr_t;

endpackage
`default_nettype wire

// File: rtl/vector_dispatch_ctrl_fifo.sv
`default_nettype none
// ============================================================================
// Module   : vdc_instr_fifo
// Purpose  : Ring-buffer instruction FIFO, head/tail pointers plus occupancy.
// Revision : 1.0
// ============================================================================
module vdc_instr_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             enq_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             deq_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_enq;
  logic             do_deq;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // No bypass: a full buffer refuses a push even while it is being popped.
  assign do_enq  = enq_i && !full_o;
  assign do_deq  = deq_i && !empty_o;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_enq) begin
      tail_d = ptr_inc(tail_q);
    end
    if (do_deq) begin
      head_d = ptr_inc(head_q);
    end
    case ({do_enq, do_deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_enq) begin
      mem_q[tail_q] <= data_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/vector_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vector_dispatch_ctrl
// Purpose  : Buffers vector instructions and sequences them onto the lanes.
// Revision : 1.0
// ============================================================================
module vector_dispatch_ctrl
  import vector_dispatch_ctrl_pkg::*;
#(
  parameter int unsigned els_p      = 32,
  parameter int unsigned vlen_p     = 8,
  parameter int unsigned vdw_p      = 32,
  parameter int unsigned lanes_p    = 4,
  parameter int unsigned op_width_p = 4,
  parameter int unsigned fifo_els_p = 2,
  parameter int unsigned timeout_p  = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     instr_v_i,
  output logic                     instr_ready_o,
  input  logic [op_width_p-1:0]    instr_op_i,
  input  logic [$clog2(els_p)-1:0] instr_vd_i,
  input  logic [$clog2(els_p)-1:0] instr_vs1_i,
  input  logic [$clog2(els_p)-1:0] instr_vs2_i,
  input  logic [vdw_p-1:0]         instr_scalar_i,
  input  logic [vdw_p-1:0]         instr_data_i,
  output logic [op_width_p-1:0]    lane_op_o,
  output logic                     lane_start_o,
  output logic [vdw_p-1:0]         lane_scalar_o,
  output logic [vdw_p-1:0]         lane_w_data_o,
  output logic [$clog2(els_p)-1:0] rf_r0_sel_o,
  output logic [$clog2(els_p)-1:0] rf_r1_sel_o,
  output logic [$clog2(els_p)-1:0] rf_w_sel_o,
  input  logic [lanes_p-1:0]       lane_done_i,
  output logic                     busy_o,
  output logic                     done_v_o,
  output logic [$clog2(els_p)-1:0] done_vd_o,
  output logic                     err_o
);

  localparam int unsigned SEL_W = $clog2(els_p);
  localparam int unsigned TMO_W = $clog2(timeout_p + 1);
  localparam int unsigned INS_W = $bits(vdc_instr_t);

  // The active-instruction struct is fixed-width; reject mismatched overrides.
  if (op_width_p != VDC_OP_W || SEL_W != VDC_REG_W || vdw_p != VDC_DW ||
      vlen_p == 0 || lanes_p == 0 || fifo_els_p == 0 || timeout_p == 0) begin : g_param_check
    $error("vector_dispatch_ctrl: unsupported parameter combination");
  end

  vdc_state_e          state_q, state_d;
  vdc_instr_t          active_q, active_d;
  logic [lanes_p-1:0]  mask_q, mask_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                err_q, err_d;

  vdc_instr_t          fifo_wdata;
  logic [INS_W-1:0]    fifo_rdata;
  logic                fifo_enq;
  logic                fifo_deq;
  logic                fifo_full;
  logic                fifo_empty;
  logic [lanes_p-1:0]  done_all;
  logic [TMO_W-1:0]    tmo_inc;

  assign fifo_wdata = '{op:     instr_op_i,
                        vd:     instr_vd_i,
                        vs1:    instr_vs1_i,
                        vs2:    instr_vs2_i,
                        scalar: instr_scalar_i,
                        data:   instr_data_i};

  assign instr_ready_o = !fifo_full && !err_q;
  assign fifo_enq      = instr_v_i && instr_ready_o;

  vdc_instr_fifo #(
    .DEPTH (fifo_els_p),
    .WIDTH (INS_W)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .enq_i     (fifo_enq),
    .data_i    (fifo_wdata),
    .deq_i     (fifo_deq),
    .data_o    (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Lanes finishing in the same cycle count toward completion immediately.
  assign done_all = mask_q | lane_done_i;
  assign tmo_inc  = tmo_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    mask_d   = mask_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    fifo_deq = 1'b0;
    case (state_q)
      s_IDLE: begin
        if (!fifo_empty) begin
          fifo_deq = 1'b1;
          active_d = vdc_instr_t'(fifo_rdata);
          state_d  = s_ISSUE;
        end
      end
      s_ISSUE: begin
        mask_d  = '0;
        tmo_d   = '0;
        state_d = s_WAIT;
      end
      s_WAIT: begin
        mask_d = done_all;
        tmo_d  = tmo_inc;
        if (&done_all) begin
          state_d = s_DONE;
        end else if (tmo_inc == TMO_W'(timeout_p)) begin
          state_d = s_ERR;
          err_d   = 1'b1;
        end
      end
      s_DONE: begin
        state_d = s_IDLE;
      end
      s_ERR: begin
        err_d = 1'b1;
      end
      default: begin
        state_d = s_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q  <= s_IDLE;
      active_q <= '0;
      mask_q   <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      mask_q   <= mask_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
    end
  end

  assign lane_start_o  = (state_q == s_ISSUE);
  assign busy_o        = (state_q == s_ISSUE) || (state_q == s_WAIT) || (state_q == s_DONE);
  assign done_v_o      = (state_q == s_DONE);
  assign done_vd_o     = done_v_o ? active_q.vd : '0;
  assign err_o         = err_q;

  assign lane_op_o     = active_q.op;
  assign lane_scalar_o = active_q.scalar;
  assign lane_w_data_o = active_q.data;
  assign rf_r0_sel_o   = active_q.vs1;
  assign rf_r1_sel_o   = active_q.vs2;
  assign rf_w_sel_o    = active_q.vd;

endmodule
`default_nettype wire

// File: tb/tb_vector_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_dispatch_ctrl
// Purpose  : Directed self-checking bench for vector_dispatch_ctrl.
// Revision : 1.0
// ============================================================================
module tb_vector_dispatch_ctrl;
  import vector_dispatch_ctrl_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        instr_v_i;
  logic        instr_ready_o;
  logic [3:0]  instr_op_i;
  logic [4:0]  instr_vd_i, instr_vs1_i, instr_vs2_i;
  logic [31:0] instr_scalar_i, instr_data_i;
  logic [3:0]  lane_op_o;
  logic        lane_start_o;
  logic [31:0] lane_scalar_o, lane_w_data_o;
  logic [4:0]  rf_r0_sel_o, rf_r1_sel_o, rf_w_sel_o;
  logic [3:0]  lane_done_i;
  logic        busy_o, done_v_o, err_o;
  logic [4:0]  done_vd_o;

  int total = 0;
  int bad   = 0;

  vector_dispatch_ctrl dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .instr_v_i      (instr_v_i),
    .instr_ready_o  (instr_ready_o),
    .instr_op_i     (instr_op_i),
    .instr_vd_i     (instr_vd_i),
    .instr_vs1_i    (instr_vs1_i),
    .instr_vs2_i    (instr_vs2_i),
    .instr_scalar_i (instr_scalar_i),
    .instr_data_i   (instr_data_i),
    .lane_op_o      (lane_op_o),
    .lane_start_o   (lane_start_o),
    .lane_scalar_o  (lane_scalar_o),
    .lane_w_data_o  (lane_w_data_o),
    .rf_r0_sel_o    (rf_r0_sel_o),
    .rf_r1_sel_o    (rf_r1_sel_o),
    .rf_w_sel_o     (rf_w_sel_o),
    .lane_done_i    (lane_done_i),
    .busy_o         (busy_o),
    .done_v_o       (done_v_o),
    .done_vd_o      (done_vd_o),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic set_instr(input logic v, input logic [3:0] op, input logic [4:0] vd,
                           input logic [4:0] vs1, input logic [4:0] vs2,
                           input logic [31:0] sc, input logic [31:0] dat);
    instr_v_i      = v;
    instr_op_i     = op;
    instr_vd_i     = vd;
    instr_vs1_i    = vs1;
    instr_vs2_i    = vs2;
    instr_scalar_i = sc;
    instr_data_i   = dat;
  endtask

  // Leaves the bench 2 time units into cycle 0, the first cycle out of reset.
  task automatic do_reset();
    set_instr(1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
    lane_done_i = 4'h0;
    reset_n_i   = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #2;
    reset_n_i = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #2;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if ({lane_start_o, done_v_o, busy_o, err_o} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=0000", {lane_start_o, done_v_o, busy_o, err_o});
    end
    total++;
    if (instr_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b exp=1", instr_ready_o);
    end
    total++;
    if ({lane_op_o, lane_scalar_o, lane_w_data_o, rf_r0_sel_o, rf_r1_sel_o, rf_w_sel_o, done_vd_o} !== '0) begin
      bad++;
      $display("FAIL reset_data got op=%h sc=%h wd=%h r0=%0d r1=%0d w=%0d vd=%0d exp all zero",
               lane_op_o, lane_scalar_o, lane_w_data_o, rf_r0_sel_o, rf_r1_sel_o, rf_w_sel_o, done_vd_o);
    end
    next_cycle();
  endtask

  task automatic test_single_op();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c == 0) set_instr(1'b1, 4'b0000, 5'd3, 5'd1, 5'd2, 32'h0, 32'h0);
      else        set_instr(1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
      lane_done_i = (c == 6) ? 4'hF : 4'h0;
      #1;
      total++;
      if (lane_start_o !== (c == 2)) begin
        bad++; $display("FAIL single_start c=%0d got=%b exp=%b", c, lane_start_o, (c == 2));
      end
      total++;
      if (done_v_o !== (c == 7)) begin
        bad++; $display("FAIL single_done c=%0d got=%b exp=%b", c, done_v_o, (c == 7));
      end
      total++;
      if (busy_o !== (c >= 2 && c <= 7)) begin
        bad++; $display("FAIL single_busy c=%0d got=%b exp=%b", c, busy_o, (c >= 2 && c <= 7));
      end
      total++;
      if (done_vd_o !== ((c == 7) ? 5'd3 : 5'd0)) begin
        bad++; $display("FAIL single_vd c=%0d got=%0d exp=%0d", c, done_vd_o, (c == 7) ? 3 : 0);
      end
      if (c >= 2 && c <= 7) begin
        total++;
        if ({rf_r0_sel_o, rf_r1_sel_o, rf_w_sel_o} !== {5'd1, 5'd2, 5'd3}) begin
          bad++; $display("FAIL single_sel c=%0d got=%0d/%0d/%0d exp=1/2/3",
                          c, rf_r0_sel_o, rf_r1_sel_o, rf_w_sel_o);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_staggered();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      if (c == 0) set_instr(1'b1, 4'b0001, 5'd5, 5'd6, 5'd7, 32'h0, 32'h0);
      else        set_instr(1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
      case (c)
        1, 2:    lane_done_i = 4'hF;
        4:       lane_done_i = 4'b0001;
        5:       lane_done_i = 4'b0110;
        8:       lane_done_i = 4'b1000;
        default: lane_done_i = 4'h0;
      endcase
      #1;
      total++;
      if (done_v_o !== (c == 9)) begin
        bad++; $display("FAIL stagger_done c=%0d got=%b exp=%b", c, done_v_o, (c == 9));
      end
      total++;
      if (busy_o !== (c >= 2 && c <= 9)) begin
        bad++; $display("FAIL stagger_busy c=%0d got=%b exp=%b", c, busy_o, (c >= 2 && c <= 9));
      end
      if (c == 9) begin
        total++;
        if (done_vd_o !== 5'd5) begin
          bad++; $display("FAIL stagger_vd got=%0d exp=5", done_vd_o);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int c = 0; c < 22; c++) begin
      case (c)
        0:       set_instr(1'b1, 4'b0001, 5'd7,  5'd0, 5'd1, 32'h0, 32'h0);
        1:       set_instr(1'b1, 4'b0001, 5'd8,  5'd0, 5'd1, 32'h0, 32'h0);
        2:       set_instr(1'b1, 4'b0001, 5'd9,  5'd0, 5'd1, 32'h0, 32'h0);
        3:       set_instr(1'b1, 4'b0001, 5'd10, 5'd0, 5'd1, 32'h0, 32'h0);
        default: set_instr(1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
      endcase
      lane_done_i = (c == 5 || c == 10 || c == 15) ? 4'hF : 4'h0;
      #1;
      total++;
      if (instr_ready_o !== !(c >= 3 && c <= 7)) begin
        bad++; $display("FAIL bp_ready c=%0d got=%b exp=%b", c, instr_ready_o, !(c >= 3 && c <= 7));
      end
      total++;
      if (lane_start_o !== (c == 2 || c == 8 || c == 13)) begin
        bad++; $display("FAIL bp_start c=%0d got=%b exp=%b", c, lane_start_o, (c == 2 || c == 8 || c == 13));
      end
      total++;
      if (done_v_o !== (c == 6 || c == 11 || c == 16)) begin
        bad++; $display("FAIL bp_done c=%0d got=%b exp=%b", c, done_v_o, (c == 6 || c == 11 || c == 16));
      end
      if (c == 6 || c == 11 || c == 16) begin
        total++;
        if (done_vd_o !== ((c == 6) ? 5'd7 : (c == 11) ? 5'd8 : 5'd9)) begin
          bad++; $display("FAIL bp_vd c=%0d got=%0d exp=%0d", c, done_vd_o,
                          (c == 6) ? 7 : (c == 11) ? 8 : 9);
        end
      end
      if (c >= 17) begin
        total++;
        if (busy_o !== 1'b0) begin
          bad++; $display("FAIL bp_idle c=%0d got=%b exp=0", c, busy_o);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int c = 0; c < 24; c++) begin
      if (c == 0)       set_instr(1'b1, 4'b0001, 5'd4,  5'd1, 5'd2, 32'h0, 32'h0);
      else if (c >= 19) set_instr(1'b1, 4'b0001, 5'd12, 5'd1, 5'd2, 32'h0, 32'h0);
      else              set_instr(1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
      lane_done_i = (c == 21) ? 4'hF : 4'h0;
      #1;
      total++;
      if (err_o !== (c >= 19)) begin
        bad++; $display("FAIL tmo_err c=%0d got=%b exp=%b", c, err_o, (c >= 19));
      end
      total++;
      if (done_v_o !== 1'b0) begin
        bad++; $display("FAIL tmo_done c=%0d got=%b exp=0", c, done_v_o);
      end
      total++;
      if (instr_ready_o !== (c < 19)) begin
        bad++; $display("FAIL tmo_ready c=%0d got=%b exp=%b", c, instr_ready_o, (c < 19));
      end
      total++;
      if (lane_start_o !== (c == 2)) begin
        bad++; $display("FAIL tmo_start c=%0d got=%b exp=%b", c, lane_start_o, (c == 2));
      end
      total++;
      if (busy_o !== (c >= 2 && c <= 18)) begin
        bad++; $display("FAIL tmo_busy c=%0d got=%b exp=%b", c, busy_o, (c >= 2 && c <= 18));
      end
      next_cycle();
    end
  endtask

  task automatic test_timeout_edge();
    do_reset();
    for (int c = 0; c < 22; c++) begin
      if (c == 0) set_instr(1'b1, 4'b0001, 5'd13, 5'd1, 5'd2, 32'h0, 32'h0);
      else        set_instr(1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
      lane_done_i = (c == 18) ? 4'hF : 4'h0;
      #1;
      total++;
      if (err_o !== 1'b0) begin
        bad++; $display("FAIL edge_err c=%0d got=%b exp=0", c, err_o);
      end
      total++;
      if (done_v_o !== (c == 19)) begin
        bad++; $display("FAIL edge_done c=%0d got=%b exp=%b", c, done_v_o, (c == 19));
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    for (int c = 0; c < 13; c++) begin
      if (c == 0)      set_instr(1'b1, 4'b0100, 5'd6,  5'd3, 5'd4, 32'h0000_1234, 32'h0000_55AA);
      else if (c == 1) set_instr(1'b1, 4'b0001, 5'd11, 5'd3, 5'd4, 32'h0, 32'h0);
      else             set_instr(1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
      reset_n_i   = (c == 5) ? 1'b0 : 1'b1;
      lane_done_i = (c == 6) ? 4'hF : 4'h0;
      #1;
      total++;
      if (done_v_o !== 1'b0) begin
        bad++; $display("FAIL rmid_done c=%0d got=%b exp=0", c, done_v_o);
      end
      total++;
      if (lane_start_o !== (c == 2)) begin
        bad++; $display("FAIL rmid_start c=%0d got=%b exp=%b", c, lane_start_o, (c == 2));
      end
      if (c == 4) begin
        total++;
        if (lane_scalar_o !== 32'h0000_1234) begin
          bad++; $display("FAIL rmid_pre got=%h exp=00001234", lane_scalar_o);
        end
      end
      if (c >= 6) begin
        total++;
        if ({busy_o, err_o, instr_ready_o} !== 3'b001) begin
          bad++; $display("FAIL rmid_ctrl c=%0d got=%b exp=001", c, {busy_o, err_o, instr_ready_o});
        end
        total++;
        if ({lane_op_o, lane_scalar_o, lane_w_data_o, rf_r0_sel_o, rf_r1_sel_o, rf_w_sel_o, done_vd_o} !== '0) begin
          bad++; $display("FAIL rmid_data c=%0d got op=%h sc=%h wd=%h r0=%0d r1=%0d w=%0d exp all zero",
                          c, lane_op_o, lane_scalar_o, lane_w_data_o, rf_r0_sel_o, rf_r1_sel_o, rf_w_sel_o);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_operand_hold();
    do_reset();
    for (int c = 0; c < 9; c++) begin
      if (c == 0) set_instr(1'b1, 4'b0100, 5'd2, 5'd10, 5'd11, 32'hDEAD_BEEF, 32'hCAFE_F00D);
      else        set_instr(1'b0, 4'hF, 5'd31, 5'd30, 5'd29, 32'h0, 32'h0);
      lane_done_i = (c == 5) ? 4'hF : 4'h0;
      #1;
      if (c >= 2 && c <= 6) begin
        total++;
        if (lane_op_o !== 4'b0100) begin
          bad++; $display("FAIL hold_op c=%0d got=%h exp=4", c, lane_op_o);
        end
        total++;
        if ({lane_scalar_o, lane_w_data_o} !== {32'hDEAD_BEEF, 32'hCAFE_F00D}) begin
          bad++; $display("FAIL hold_operands c=%0d got=%h/%h exp=deadbeef/cafef00d",
                          c, lane_scalar_o, lane_w_data_o);
        end
        total++;
        if ({rf_r0_sel_o, rf_r1_sel_o, rf_w_sel_o} !== {5'd10, 5'd11, 5'd2}) begin
          bad++; $display("FAIL hold_sel c=%0d got=%0d/%0d/%0d exp=10/11/2",
                          c, rf_r0_sel_o, rf_r1_sel_o, rf_w_sel_o);
        end
      end
      total++;
      if (done_v_o !== (c == 6)) begin
        bad++; $display("FAIL hold_done c=%0d got=%b exp=%b", c, done_v_o, (c == 6));
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 11; c++) begin
      if (c == 0)      set_instr(1'b1, VDC_OP_READ, 5'd1, 5'd20, 5'd21, 32'h0, 32'h0);
      else if (c == 1) set_instr(1'b1, 4'b0001, 5'd2, 5'd22, 5'd23, 32'h0, 32'h0);
      else             set_instr(1'b0, 4'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
      lane_done_i = 4'hF;
      #1;
      total++;
      if (lane_start_o !== (c == 2 || c == 6)) begin
        bad++; $display("FAIL b2b_start c=%0d got=%b exp=%b", c, lane_start_o, (c == 2 || c == 6));
      end
      total++;
      if (done_v_o !== (c == 4 || c == 8)) begin
        bad++; $display("FAIL b2b_done c=%0d got=%b exp=%b", c, done_v_o, (c == 4 || c == 8));
      end
      total++;
      if (busy_o !== ((c >= 2 && c <= 4) || (c >= 6 && c <= 8))) begin
        bad++; $display("FAIL b2b_busy c=%0d got=%b exp=%b", c, busy_o,
                        ((c >= 2 && c <= 4) || (c >= 6 && c <= 8)));
      end
      if (c >= 2 && c <= 4) begin
        total++;
        if ({lane_op_o, rf_w_sel_o} !== {4'b1000, 5'd1}) begin
          bad++; $display("FAIL b2b_read_op c=%0d got=%h/%0d exp=8/1", c, lane_op_o, rf_w_sel_o);
        end
      end
      if (c >= 6 && c <= 8) begin
        total++;
        if ({lane_op_o, rf_w_sel_o} !== {4'b0001, 5'd2}) begin
          bad++; $display("FAIL b2b_second_op c=%0d got=%h/%0d exp=1/2", c, lane_op_o, rf_w_sel_o);
        end
      end
      if (c == 4 || c == 8) begin
        total++;
        if (done_vd_o !== ((c == 4) ? 5'd1 : 5'd2)) begin
          bad++; $display("FAIL b2b_vd c=%0d got=%0d exp=%0d", c, done_vd_o, (c == 4) ? 1 : 2);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_staggered();
    test_backpressure();
    test_timeout();
    test_timeout_edge();
    test_reset_mid_op();
    test_operand_hold();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vector_dispatch_ctrl.md
VECTOR_DISPATCH_CTRL -- requirements
Module: vector_dispatch_ctrl

Interface
REQ-001 Params: els_p=32 (vector registers); vlen_p=8 (elements/vector); vdw_p=32 (element bits); lanes_p=4 (lane count); op_width_p=4 (opcode bits); fifo_els_p=2 (instruction buffer depth); timeout_p=16 (max WAIT cycles).
REQ-002 Ports, one per line, clock and reset first:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset, synchronous, active-low.
- instr_v_i  in  1  instruction valid.
- instr_ready_o  out  1  instruction accepted when high with instr_v_i.
- instr_op_i  in  op_width_p  opcode.
- instr_vd_i, instr_vs1_i, instr_vs2_i  in  clog2(els_p) each  dest/src registers.
- instr_scalar_i, instr_data_i  in  vdw_p each  scalar operand / external write data.
- lane_op_o  out  op_width_p  opcode broadcast to all lanes.
- lane_start_o  out  1  start pulse to all lanes.
- lane_scalar_o, lane_w_data_o  out  vdw_p each  operands to lanes.
- rf_r0_sel_o, rf_r1_sel_o, rf_w_sel_o  out  clog2(els_p) each  register-file vector selects.
- lane_done_i  in  lanes_p  per-lane done.
- busy_o  out  1  instruction in flight.
- done_v_o  out  1  one-cycle completion pulse.
- done_vd_o  out  clog2(els_p)  vd of completed instruction.
- err_o  out  1  sticky timeout error.

Function
REQ-003 Instruction FIFO of fifo_els_p entries; instr_ready_o = !full && !err_o; enqueue on instr_v_i && instr_ready_o; no bypass, so a full FIFO refuses enqueue even in a dequeue cycle.
REQ-004 FSM states s_IDLE, s_ISSUE, s_WAIT, s_DONE, s_ERR.
REQ-005 s_IDLE -> s_ISSUE when FIFO non-empty; head is dequeued into the active-instruction register on that transition.
REQ-006 s_ISSUE lasts exactly one cycle; lane_start_o=1 only in s_ISSUE; the done mask and timeout counter clear; next state s_WAIT.
REQ-007 s_WAIT: done mask |= lane_done_i each cycle; go to s_DONE in the cycle where (mask | lane_done_i) is all ones, including lanes finishing in that same cycle.
REQ-008 s_WAIT timeout: counter increments each s_WAIT cycle; if it reaches timeout_p without completion, go to s_ERR; completion and timeout in the same cycle resolve to s_DONE.
REQ-009 s_DONE lasts one cycle: done_v_o=1 and done_vd_o=active vd; then s_IDLE. Back-to-back instructions therefore have a minimum gap of one s_IDLE cycle.
REQ-010 s_ERR is terminal until reset; err_o=1; instr_ready_o=0; no further lane_start_o.
REQ-011 lane_op_o, lane_scalar_o, lane_w_data_o and rf_*_sel_o come from the active-instruction register and hold stable from s_ISSUE through s_DONE. Lanes resample operands every cycle and use the opcode combinationally at writeback.
REQ-012 rf_r0_sel_o=vs1; rf_r1_sel_o=vs2; rf_w_sel_o=vd. Opcode 4'b1000 (read) is passed through unchanged; lanes suppress the write themselves.
REQ-013 busy_o=1 in s_ISSUE, s_WAIT and s_DONE.
REQ-014 lane_done_i outside s_WAIT is ignored.

Reset
REQ-015 While reset_n_i=0 at a clock edge: FSM goes to s_IDLE; FIFO empties; done mask, timeout counter and err_o clear; lane_start_o, done_v_o and busy_o are 0; lane_op_o, lane_scalar_o, lane_w_data_o, rf_*_sel_o and done_vd_o are 0.
REQ-016 Reset in any state, including mid-s_WAIT, aborts the instruction without a done_v_o pulse. instr_ready_o=1 in the first cycle after reset deasserts.

Structure
REQ-017 The shared package holds the state enum, the opcode constants (read=4'b1000; op[3] = external data; op[2] = scalar operand) and the active-instruction struct {op, vd, vs1, vs2, scalar, data}.
REQ-018 The FIFO is one sub-module, vdc_instr_fifo (ring buffer with head/tail pointers and an occupancy count); the FSM, done mask and timeout counter stay in the top module.

Verification
REQ-019 Single op: add op=4'b0000, vd=3, vs1=1, vs2=2 accepted at cycle 0 from reset idle; all lanes raise done at cycle 6 -> lane_start_o at cycle 2, done_v_o at cycle 7 with done_vd_o=3.
REQ-020 Staggered done: lanes 0..3 raise done at cycles 4, 5, 5, 8 (single-cycle pulses) -> one done_v_o, at cycle 9.
REQ-021 Backpressure: present 3 instructions back-to-back while no lane responds -> instr_ready_o=0 once 2 entries are buffered plus 1 active; the instructions later complete in order with vd values matching.
REQ-022 Timeout: no lane_done_i after a start -> err_o=1 timeout_p cycles into s_WAIT, no done_v_o, instr_ready_o stays 0.
REQ-023 Reset mid-op: reset_n_i=0 for one cycle during s_WAIT -> no done_v_o; all outputs return to reset values; FIFO empty.
REQ-024 Operand hold: scalar op 4'b0100 with scalar=0xDEADBEEF -> lane_scalar_o and lane_op_o hold constant from lane_start_o through done_v_o.
